logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the transaction counter.
REQ-003 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  function select, sampled with the beat.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 y  output  WIDTH  registered result.
REQ-013 flag_zero  output  1  y is all zeros (see Configuration).
REQ-014 flag_parity  output  1  XOR-reduction of y (see Configuration).
REQ-015 txn_count  output  CNT_W  number of results delivered downstream.

Function
REQ-016 The block SHALL decode op bitwise over WIDTH bits as follows:
- 000 a&b
- 001 a|b
- 010 ~a (b ignored)
- 011 ~(a&b)
- 100 ~(a|b)
- 101 a^b
- 110 ~(a^b)
- 111 a (pass)
REQ-017 The block SHALL be a two-stage pipeline.
- S1 registers a, b and op.
- S2 computes the function from the S1 contents and registers y and the flags.
- Latency from input handshake to out_valid SHALL be 2 cycles.
REQ-018 A beat SHALL transfer on the input when in_valid&in_ready, and on the output when out_valid&out_ready.
REQ-019 S2 SHALL accept when out_valid=0 or out_ready=1.
REQ-020 in_ready SHALL equal (S1 empty) | (S2 accepts), combinationally, with no dependence on in_valid.
REQ-021 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-022 While out_valid=1 and out_ready=0, y, the flags and out_valid SHALL hold stable.
REQ-023 Under a stall, S1 SHALL hold its beat, and in_ready SHALL fall once S1 is full.
REQ-024 No beat SHALL be dropped or duplicated.
REQ-025 When a beat enters S1 in the same cycle that S1 drains into S2, both transfers SHALL occur.
REQ-026 When a beat enters S2 in the same cycle that the output handshake completes, the new result SHALL replace the old one and out_valid SHALL stay 1.
REQ-027 txn_count SHALL increment by 1 on each output handshake and SHALL wrap from all-ones to 0.
REQ-028 Inputs sampled while in_ready=0 SHALL have no effect.

Reset
REQ-029 Asserting rst SHALL immediately clear both stage valid bits.
REQ-030 Asserting rst SHALL immediately set y, flag_zero, flag_parity and txn_count to 0; in_ready SHALL then read 1 (S1 empty).
REQ-031 A reset asserted mid-transfer SHALL discard all in-flight beats, with no partial output after deassertion.
REQ-032 The first accepted beat after reset deassertion SHALL appear 2 cycles later.

Configuration
REQ-033 Macro LOGIC_UNIT_FLAGS_EN SHALL control the flag outputs.
- Defined: flag_zero and flag_parity are computed from the S2 result and registered with y, with the same latency and stall behaviour.
- Undefined: no flag logic is built, and both ports SHALL be tied to constant 0.

Verification
REQ-034 Scenario 1 (op sweep, WIDTH=8): a=0xC5, b=0x3A, op 0..7 back-to-back with out_ready=1 -> y = 0x00, 0xFF, 0x3A, 0xFF, 0x00, 0xFF, 0x00, 0xC5 on consecutive cycles, first result 2 cycles after the first handshake; txn_count=8 at the end.
REQ-035 Scenario 2 (flags, LOGIC_UNIT_FLAGS_EN defined): a=0xF0, b=0x0F, op=000 -> y=0x00, flag_zero=1, flag_parity=0. Then op=101 -> y=0xFF, flag_zero=0, flag_parity=0. Then a=0x01, op=111 -> flag_parity=1. Without the macro, both flags are always 0.
REQ-036 Scenario 3 (stall): stream 4 beats, hold out_ready=0 for 5 cycles -> in_ready=0 once both stages are full, y holds stable; on release all 4 results emerge in order with no loss.
REQ-037 Scenario 4 (reset mid-operation): 2 beats in flight, assert rst asynchronously between edges -> out_valid=0 and txn_count=0 immediately, and no stale result after deassertion.
REQ-038 Scenario 5 (counter wrap): CNT_W=4, deliver 17 beats -> txn_count reads 15 after beat 15, 0 after beat 16, 1 after beat 17.
REQ-039 Scenario 6 (random): random in_valid/out_ready at 50% each, 1000 beats -> output stream matches the reference model order and values exactly.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with delivered-result counter.
// Optional flags: define LOGIC_UNIT_FLAGS_EN to build flag_zero/flag_parity.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             flag_zero,
   output logic             flag_parity,
   output logic [CNT_W-1:0] txn_count
);

   logic             r_s1_v;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_s2_v;
   logic [WIDTH-1:0] r_y;
   logic [CNT_W-1:0] r_cnt;

   logic             w_s2_acc;
   logic             w_in_fire;
   logic             w_out_fire;
   logic [WIDTH-1:0] w_f;

   assign w_s2_acc   = ~r_s2_v | out_ready;
   assign in_ready   = ~r_s1_v | w_s2_acc;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_s2_v & out_ready;

   always_comb begin
      w_f = '0;
      unique case (r_op)
         3'b000: w_f = r_a & r_b;
         3'b001: w_f = r_a | r_b;
         3'b010: w_f = ~r_a;
         3'b011: w_f = ~(r_a & r_b);
         3'b100: w_f = ~(r_a | r_b);
         3'b101: w_f = r_a ^ r_b;
         3'b110: w_f = ~(r_a ^ r_b);
         3'b111: w_f = r_a;
      endcase
   end

   // S1 refills in the same cycle it drains into S2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
         r_op   <= '0;
      end else if (w_in_fire) begin
         r_s1_v <= 1'b1;
         r_a    <= a;
         r_b    <= b;
         r_op   <= op;
      end else if (w_s2_acc) begin
         r_s1_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v <= 1'b0;
         r_y    <= '0;
      end else if (w_s2_acc) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) r_y <= w_f;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_cnt <= '0;
      else if (w_out_fire) r_cnt <= r_cnt + 1'b1;
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   logic r_fz;
   logic r_fp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fz <= 1'b0;
         r_fp <= 1'b0;
      end else if (w_s2_acc && r_s1_v) begin
         r_fz <= ~|w_f;
         r_fp <= ^w_f;
      end
   end

   assign flag_zero   = r_fz;
   assign flag_parity = r_fp;
`else
   assign flag_zero   = 1'b0;
   assign flag_parity = 1'b0;
`endif

   assign out_valid = r_s2_v;
   assign y         = r_y;
   assign txn_count = r_cnt;

endmodule
